// File: rtl/uart_wrapper.sv
// UART front end: receives two-byte host commands on RX and transmits one-byte responses on TX.
// Receiver, command assembler and transmitter run independently (full duplex).
module uart_wrapper #(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    // state     | meaning
    // RX_IDLE   | waiting for a falling edge on synchronized RX
    // RX_START  | timing to mid start bit, rejecting glitches
    // RX_DATA   | sampling 8 data bits, LSB first
    // RX_STOP   | timing to the stop-bit sample point
    // ASM_HIGH  | next received byte is cmd[15:8]
    // ASM_LOW   | next received byte is cmd[7:0]
    // TX_IDLE   | TX held high, waiting for send_resp
    // TX_XMIT   | shifting out start, 8 data, stop bits
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] DIV    = CW'(BAUD_DIV);
    localparam logic [CW-1:0] DIV_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] ONE    = CW'(1);

    rx_state_t   rx_state;
    asm_state_t  asm_state;
    tx_state_t   tx_state;

    logic          rx_meta, rx_sync;
    logic [CW-1:0] rx_cnt, tx_cnt;
    logic [2:0]    rx_bits;
    logic [3:0]    tx_bits;
    logic [7:0]    rx_shift;
    logic [9:0]    tx_shift;
    logic          byte_done, start_ok, rx_tick;

    // A counter loaded with N expires N cycles later; <= 1 also covers a zero load.
    assign rx_tick = (rx_cnt <= ONE);
    assign TX      = tx_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            byte_done <= 1'b0;
            start_ok  <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            start_ok  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                            rx_cnt   <= '0;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= DIV;
                            rx_bits  <= '0;
                            start_ok <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_cnt   <= DIV;
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                        else                 rx_bits  <= rx_bits + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        byte_done <= 1'b1;
                        rx_state  <= RX_IDLE;
                        rx_cnt    <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - ONE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A completed command wins over a clear landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= ASM_HIGH;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (byte_done) begin
                if (asm_state == ASM_LOW) begin
                    cmd[7:0]  <= rx_shift;
                    asm_state <= ASM_HIGH;
                end else begin
                    cmd[15:8] <= rx_shift;
                    asm_state <= ASM_LOW;
                end
            end
            if (byte_done && asm_state == ASM_LOW)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || (start_ok && asm_state == ASM_HIGH))
                cmd_rdy <= 1'b0;
        end
    end

    // The zero count on entry marks the first cycle of the start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_bits   <= '0;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_shift <= {1'b1, resp, 1'b0};
                        tx_bits  <= '0;
                        tx_cnt   <= '0;
                        tx_state <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= DIV_M1;
                    end else if (tx_cnt == ONE) begin
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        tx_cnt   <= DIV;
                        if (tx_bits == 4'd9) begin
                            tx_state  <= TX_IDLE;
                            resp_sent <= 1'b1;
                            tx_cnt    <= '0;
                        end else begin
                            tx_bits <= tx_bits + 4'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wrapper.sv
// Self-checking bench for uart_wrapper at BAUD_DIV=16: command and TX-bit scoreboards.
module tb_uart_wrapper;
    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx = 1'b1;
    logic        tx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned lo_start = 0;
    int          rs_count = 0;
    int          rdy_rises = 0;
    logic [15:0] cmd_q[$];
    logic        tx_q[$];
    logic        prev_rdy = 1'b0;
    logic [15:0] prev_cmd = '0;

    always #5 clk = ~clk;

    uart_wrapper #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Command scoreboard: pop one expected command on each cmd_rdy rise.
    always @(negedge clk) begin
        if (resp_sent) rs_count++;
        if (cmd_rdy && !prev_rdy) begin
            rdy_rises++;
            chk("cmd_q_nonempty", {31'd0, cmd_q.size() != 0}, 32'd1);
            if (cmd_q.size() != 0) chk("cmd", {16'd0, cmd}, {16'd0, cmd_q.pop_front()});
            chk("rdy_latency", cyc - lo_start, 32'd156);
        end else if (cmd_rdy && prev_rdy && cmd !== prev_cmd) begin
            chk("cmd_stable", {16'd0, cmd}, {16'd0, prev_cmd});
        end
        prev_rdy = cmd_rdy;
        prev_cmd = cmd;
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (BD) @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
        cmd_q.push_back({hi, lo});
        send_byte(hi);
        chk("no_rdy_after_hi", {31'd0, cmd_rdy}, 32'd0);
        lo_start = cyc;
        send_byte(lo);
    endtask

    // Checks every TX cycle of a frame; poke issues a second send_resp mid-frame.
    task automatic tx_frame(input logic [7:0] r, input logic poke);
        logic [9:0] fr;
        logic       e;
        fr = {1'b1, r, 1'b0};
        for (int i = 0; i < 10; i++) tx_q.push_back(fr[i]);
        resp = r;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int b = 0; b < 10; b++) begin
            e = tx_q.pop_front();
            for (int c = 0; c < BD; c++) begin
                chk("tx_bit", {31'd0, tx}, {31'd0, e});
                if (poke && b == 4 && c == 3) begin
                    resp = 8'h0F;
                    send_resp = 1'b1;
                end else begin
                    send_resp = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk("resp_sent_pulse", {31'd0, resp_sent}, 32'd1);
        @(negedge clk);
        chk("resp_sent_one_cycle", {31'd0, resp_sent}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rises0;
        logic saw_low;
        logic found;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_cmd", {16'd0, cmd}, 32'd0);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_cmd(8'hA5, 8'h3C);
        repeat (5) @(negedge clk);
        chk("rdy_held", {31'd0, cmd_rdy}, 32'd1);

        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("clr_cmd_kept", {16'd0, cmd}, 32'h0000A53C);

        rises0 = rdy_rises;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_cmd", {16'd0, cmd}, 32'h0000A53C);
        chk("glitch_no_rdy", rdy_rises, rises0);
        send_cmd(8'h5A, 8'hF0);
        repeat (5) @(negedge clk);

        tx_frame(8'hC3, 1'b1);
        saw_low = 1'b0;
        repeat (180) begin
            if (!tx) saw_low = 1'b1;
            @(negedge clk);
        end
        chk("tx_ignored_send", {31'd0, saw_low}, 32'd0);
        chk("resp_sent_count1", rs_count, 1);

        resp = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BD + BD / 2) @(negedge clk);
        chk("tx_pre_rst", {31'd0, tx}, 32'd0);
        rises0 = rdy_rises;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_cmd", {16'd0, cmd}, 32'd0);
        chk("midrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        saw_low = 1'b0;
        repeat (200) begin
            if (!tx) saw_low = 1'b1;
            @(negedge clk);
        end
        chk("postrst_tx_idle", {31'd0, saw_low}, 32'd0);
        chk("postrst_no_resp_sent", rs_count, 1);
        chk("postrst_no_rdy", rdy_rises, rises0);
        send_cmd(8'h12, 8'h34);
        repeat (5) @(negedge clk);

        fork
            send_cmd(8'hDE, 8'hAD);
            tx_frame(8'h96, 1'b0);
            begin
                repeat (2 * 10 * BD - 10) @(negedge clk);
                clr_cmd_rdy = 1'b1;
                found = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    if (cmd_rdy) begin
                        found = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                clr_cmd_rdy = 1'b0;
                chk("set_wins_seen", {31'd0, found}, 32'd1);
                repeat (3) @(negedge clk);
                chk("set_wins_hold", {31'd0, cmd_rdy}, 32'd1);
            end
        join
        repeat (20) @(negedge clk);
        chk("resp_sent_count2", rs_count, 2);
        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("final_cmd", {16'd0, cmd}, 32'h0000DEAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
